// File: rtl/vec_mem_pkg.sv
// Shared types and default sizing for the vector memory sequencer.
package vec_mem_pkg;

  localparam int DEF_LANES  = 4;
  localparam int DEF_ELEM_W = 16;
  localparam int DEF_ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    FINISH = 2'd2
  } seqState_t;

endpackage

// File: rtl/vec_mem_sequencer.sv
// Serialises a scalar/vector load or store into one memory access per element; start-to-done
// is elements+1 cycles minimum, each access held until mem_ack, upstream frozen via stall.
module vec_mem_sequencer
  import vec_mem_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int ELEM_W = DEF_ELEM_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    is_store,
  input  logic                    is_vec,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [LANES*ELEM_W-1:0] wdata_vec,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [ELEM_W-1:0]       mem_wdata,
  input  logic [ELEM_W-1:0]       mem_rdata,
  input  logic                    mem_ack,
  output logic                    stall,
  output logic                    busy,
  output logic                    done,
  output logic [LANES*ELEM_W-1:0] rdata_vec
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  seqState_t               state, stateNext;
  logic [IDX_W-1:0]        idx;
  logic                    capStore, capVec;
  logic [ADDR_W-1:0]       capBase;
  logic [LANES*ELEM_W-1:0] capWdata;
  logic [LANES*ELEM_W-1:0] rdataReg;
  logic [ELEM_W-1:0]       curWdata;
  logic                    isLast;
  logic                    accept;
  logic                    ackTaken;

  assign isLast    = capVec ? (idx == IDX_W'(LANES - 1)) : (idx == '0);
  assign accept    = (state == IDLE) && start;
  assign ackTaken  = (state == ACCESS) && mem_ack;
  assign rdata_vec = rdataReg;

  always_comb begin
    curWdata = '0;
    for (int i = 0; i < LANES; i++) begin
      if (idx == IDX_W'(i)) curWdata = capWdata[i*ELEM_W +: ELEM_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    done      = 1'b0;
    busy      = 1'b1;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        busy  = 1'b0;
        // A start must freeze decode in the same cycle it is presented.
        stall = start && !rst;
        if (start) stateNext = ACCESS;
      end
      ACCESS: begin
        mem_req   = 1'b1;
        mem_we    = capStore;
        mem_addr  = capBase + ADDR_W'(idx);
        mem_wdata = curWdata;
        stall     = 1'b1;
        if (mem_ack && isLast) stateNext = FINISH;
      end
      FINISH: begin
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: begin
        busy      = 1'b0;
        stateNext = IDLE;
      end
    endcase
  end

  // Operands are only sampled from IDLE, so starts seen while busy cannot disturb them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      capStore <= 1'b0;
      capVec   <= 1'b0;
      capBase  <= '0;
      capWdata <= '0;
      rdataReg <= '0;
    end else if (accept) begin
      idx      <= '0;
      capStore <= is_store;
      capVec   <= is_vec;
      capBase  <= base_addr;
      capWdata <= wdata_vec;
    end else if (ackTaken) begin
      if (!capStore) begin
        for (int i = 0; i < LANES; i++) begin
          if (idx == IDX_W'(i)) rdataReg[i*ELEM_W +: ELEM_W] <= mem_rdata;
        end
      end
      if (!isLast) idx <= idx + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Randomised and directed bench for vec_mem_sequencer against an element-list reference model.
module tb_vec_mem_sequencer;

  localparam int LANES  = 4;
  localparam int ELEM_W = 16;
  localparam int ADDR_W = 32;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic                    isStore;
  logic                    isVec;
  logic [ADDR_W-1:0]       baseAddr;
  logic [LANES*ELEM_W-1:0] wdataVec;
  logic                    memReq;
  logic                    memWe;
  logic [ADDR_W-1:0]       memAddr;
  logic [ELEM_W-1:0]       memWdata;
  logic [ELEM_W-1:0]       memRdata;
  logic                    memAck;
  logic                    stall;
  logic                    busy;
  logic                    done;
  logic [LANES*ELEM_W-1:0] rdataVec;

  logic [LANES*ELEM_W-1:0] rdModel;
  int nChecks = 0;
  int nPass   = 0;

  vec_mem_sequencer #(.LANES(LANES), .ELEM_W(ELEM_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .is_store(isStore), .is_vec(isVec),
    .base_addr(baseAddr), .wdata_vec(wdataVec), .mem_req(memReq), .mem_we(memWe),
    .mem_addr(memAddr), .mem_wdata(memWdata), .mem_rdata(memRdata), .mem_ack(memAck),
    .stall(stall), .busy(busy), .done(done), .rdata_vec(rdataVec)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic scrambleOperands();
    isStore  = 1'($urandom);
    isVec    = 1'($urandom);
    baseAddr = $urandom;
    wdataVec = {$urandom, $urandom};
  endtask

  // One complete op: the model is the ordered list of element accesses base+e (mod 2^32).
  task automatic runOp(input logic st, input logic vec, input logic [ADDR_W-1:0] base,
                       input logic [LANES*ELEM_W-1:0] wd, input logic [LANES*ELEM_W-1:0] rdPat,
                       input int fixedDelay, input bit inject);
    int n, dly, sumWaits, cycles;
    logic [ADDR_W-1:0] ea;
    n = vec ? LANES : 1;
    sumWaits = 0;
    @(negedge clk);
    start = 1'b1; isStore = st; isVec = vec; baseAddr = base; wdataVec = wd;
    #1;
    check("startStall", 64'(stall), 64'd1);
    check("startBusy", 64'(busy), 64'd0);
    check("startReq", 64'(memReq), 64'd0);
    @(negedge clk);
    cycles = 1;
    start = 1'b0;
    for (int e = 0; e < n; e++) begin
      dly = (fixedDelay >= 0) ? fixedDelay : int'($urandom_range(0, 3));
      sumWaits += dly;
      ea = base + ADDR_W'(e);
      for (int w = 0; w <= dly; w++) begin
        check("req", 64'(memReq), 64'd1);
        check("addr", 64'(memAddr), 64'(ea));
        check("we", 64'(memWe), 64'(st));
        check("wdata", 64'(memWdata), 64'(wd[e*ELEM_W +: ELEM_W]));
        check("accStall", 64'(stall), 64'd1);
        check("accBusy", 64'(busy), 64'd1);
        check("accDone", 64'(done), 64'd0);
        if (inject && $urandom_range(0, 2) == 0) begin
          start = 1'b1;
          scrambleOperands();
        end else start = 1'b0;
        memAck   = (w == dly);
        memRdata = (w == dly) ? rdPat[e*ELEM_W +: ELEM_W] : ELEM_W'($urandom);
        @(negedge clk);
        cycles++;
      end
    end
    check("finDone", 64'(done), 64'd1);
    check("finReq", 64'(memReq), 64'd0);
    check("finBusy", 64'(busy), 64'd1);
    check("finStall", 64'(stall), 64'd0);
    check("latency", 64'(cycles), 64'(n + 1 + sumWaits));
    start = inject;
    if (inject) scrambleOperands();
    memAck   = inject;
    memRdata = ELEM_W'($urandom);
    @(negedge clk);
    check("postDone", 64'(done), 64'd0);
    check("postBusy", 64'(busy), 64'd0);
    check("postReq", 64'(memReq), 64'd0);
    start  = 1'b0;
    memAck = 1'b0;
    if (!st) begin
      if (vec) rdModel = rdPat;
      else     rdModel[ELEM_W-1:0] = rdPat[ELEM_W-1:0];
    end
    check("rdataVec", 64'(rdataVec), 64'(rdModel));
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "Req"}, 64'(memReq), 64'd0);
    check({tag, "We"}, 64'(memWe), 64'd0);
    check({tag, "Addr"}, 64'(memAddr), 64'd0);
    check({tag, "Wdata"}, 64'(memWdata), 64'd0);
    check({tag, "Done"}, 64'(done), 64'd0);
    check({tag, "Busy"}, 64'(busy), 64'd0);
    check({tag, "Stall"}, 64'(stall), 64'd0);
    check({tag, "Rdata"}, 64'(rdataVec), 64'd0);
  endtask

  task automatic midOpReset();
    @(negedge clk);
    start = 1'b1; isStore = 1'b0; isVec = 1'b1; baseAddr = 32'h300; wdataVec = '0;
    @(negedge clk);
    start = 1'b0; memAck = 1'b1; memRdata = 16'h1111;
    @(negedge clk);
    memAck = 1'b1; memRdata = 16'h2222;
    @(negedge clk);
    memAck = 1'b0;
    check("preRstAddr", 64'(memAddr), 64'h302);
    rst = 1'b1;
    #1;
    rdModel = '0;
    checkResetOutputs("midRst");
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("relReq", 64'(memReq), 64'd0);
      check("relDone", 64'(done), 64'd0);
      check("relBusy", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    logic [LANES*ELEM_W-1:0] pat;
    logic [ADDR_W-1:0] b;
    rst = 1'b1; start = 1'b1; isStore = 1'b0; isVec = 1'b0; baseAddr = '0; wdataVec = '0;
    memAck = 1'b0; memRdata = '0; rdModel = '0;
    #2;
    checkResetOutputs("rst");
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    pat = {16'd4, 16'd3, 16'd2, 16'd1};
    runOp(1'b1, 1'b1, 32'h100, pat, '0, 0, 1'b0);
    pat = {16'hA3, 16'hA2, 16'hA1, 16'hA0};
    runOp(1'b0, 1'b1, 32'h200, '0, pat, 2, 1'b0);
    pat = {16'hEEEE, 16'hDDDD, 16'hCCCC, 16'h0055};
    runOp(1'b0, 1'b0, 32'h10, '0, pat, 0, 1'b0);
    pat = {16'h0BAD, 16'h0BAD, 16'h0BAD, 16'h0BAD};
    runOp(1'b1, 1'b1, 32'h400, {16'h9, 16'h8, 16'h7, 16'h6}, pat, 1, 1'b1);
    runOp(1'b0, 1'b1, 32'hFFFF_FFFE, '0, {16'h4, 16'h3, 16'h2, 16'h1}, -1, 1'b1);

    for (int k = 0; k < 30; k++) begin
      b = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + ADDR_W'($urandom_range(0, 3))) : $urandom;
      runOp(1'($urandom), 1'($urandom), b, {$urandom, $urandom}, {$urandom, $urandom}, -1,
            1'($urandom));
    end

    midOpReset();
    runOp(1'b0, 1'b1, 32'h500, '0, {$urandom, $urandom}, -1, 1'b0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
